// File: rtl/tt_pinbus_responder.sv
// Pin-level register responder: an asynchronous host strobe handshake over the
// tile pins gives access to seven R/W registers and a read-only transaction counter.

module tt_pinbus_regfile #(
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          cnt_inc,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [7:0]    reg0
);
    localparam int CNT_ADDR = NREG - 1;

    logic [7:0] regs [NREG];

    // The top address is the transaction counter; host writes to it are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            if (wr_en && (int'(wr_addr) != CNT_ADDR)) begin
                regs[wr_addr] <= wr_data;
            end
            if (cnt_inc) begin
                regs[CNT_ADDR] <= regs[CNT_ADDR] + 8'd1;
            end
        end
    end

    assign rd_data = regs[rd_addr];
    assign reg0    = regs[0];
endmodule

// state | meaning
// IDLE  | waiting for a synchronized, armed, enabled strobe
// DRIVE | read data on the pads, one settling cycle before ack
// ACK   | ack high until the synchronized strobe drops
// TURN  | ack low, pads released, one cycle before returning to IDLE
module tt_pinbus_responder #(
    parameter int NREG = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int AW = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        ACK   = 2'd2,
        TURN  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic       stb_pin;
    logic       rnw_pin;
    logic [2:0] addr_pin;

    logic       stb_m;
    logic       stb_s;
    logic [1:0] sync_fill;
    logic       armed;
    logic       txn_rd;
    logic [7:0] rd_q;

    logic       accept;
    logic       wr_en;
    logic       cnt_inc;
    logic [7:0] rd_data;
    logic [7:0] reg0;

    logic       ack;
    logic       oe_drive;
    logic       unused_bits;

    assign stb_pin     = ui_in[7];
    assign rnw_pin     = ui_in[6];
    assign addr_pin    = ui_in[2:0];
    assign unused_bits = ^{ui_in[5:3], reg0[7]};

    assign accept  = (state == IDLE) && stb_s && armed && ena;
    assign wr_en   = accept && !rnw_pin;
    assign cnt_inc = wr_en || (state == DRIVE);

    // Synchronizer outputs are only trusted once both flops hold real pin samples,
    // so the reset value of stb_s cannot arm a strobe that was high across reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stb_m     <= 1'b0;
            stb_s     <= 1'b0;
            sync_fill <= 2'd2;
        end else begin
            stb_m <= stb_pin;
            stb_s <= stb_m;
            if (sync_fill != 2'd0) begin
                sync_fill <= sync_fill - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            armed  <= 1'b0;
            txn_rd <= 1'b0;
            rd_q   <= 8'h00;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && !stb_s && (sync_fill == 2'd0)) begin
                armed <= 1'b1;
            end
            if (accept) begin
                txn_rd <= rnw_pin;
                if (rnw_pin) begin
                    rd_q <= rd_data;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = rnw_pin ? DRIVE : ACK;
            DRIVE:   state_nxt = ACK;
            ACK:     if (!stb_s) state_nxt = TURN;
            TURN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ack      = 1'b0;
        oe_drive = 1'b0;
        case (state)
            DRIVE: oe_drive = 1'b1;
            ACK: begin
                ack      = 1'b1;
                oe_drive = txn_rd;
            end
            default: begin
                ack      = 1'b0;
                oe_drive = 1'b0;
            end
        endcase
    end

    assign uo_out  = {ack, reg0[6:0]};
    assign uio_out = rd_q;
    assign uio_oe  = oe_drive ? 8'hFF : 8'h00;

    tt_pinbus_regfile #(
        .NREG (NREG),
        .AW   (AW)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (addr_pin),
        .wr_data (uio_in),
        .cnt_inc (cnt_inc),
        .rd_addr (addr_pin),
        .rd_data (rd_data),
        .reg0    (reg0)
    );
endmodule
